// File: rtl/ft_restore_ctrl.sv
// Rollback restore initiator: reads checkpointed x1..x(NUM_REGS-1) and the PC back
// over a req/gnt/rvalid port and replays them as RF writes and a PC load.
// Optional wait-state watchdog enabled by defining FT_RESTORE_TIMEOUT_EN.
module ft_restore_ctrl #(
  parameter int unsigned NUM_REGS  = 32,
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter logic [31:0] PC_ADDR   = 32'h0000_0200,
  parameter int unsigned TIMEOUT   = 15
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        start_i,
  output logic        busy_o,
  output logic        done_o,
  output logic        err_o,
  output logic        req_o,
  output logic [31:0] addr_o,
  input  logic        gnt_i,
  input  logic        rvalid_i,
  input  logic [31:0] rdata_i,
  input  logic        err_i,
  output logic        we_rf_o,
  output logic [4:0]  addr_rf_o,
  output logic [31:0] data_rf_o,
  output logic        pc_we_o,
  output logic [31:0] pc_o
);

  localparam logic [2:0] S_IDLE     = 3'd0;
  localparam logic [2:0] S_REQ      = 3'd1;
  localparam logic [2:0] S_GNT_WAIT = 3'd2;
  localparam logic [2:0] S_RV_WAIT  = 3'd3;
  localparam logic [2:0] S_WRITE    = 3'd4;
  localparam logic [2:0] S_DONE     = 3'd5;

  localparam logic [5:0] PC_SLOT = 6'(NUM_REGS);

  logic [2:0]  state_q, state_d;
  logic [5:0]  idx_q, idx_d;
  logic        err_q, err_d;
  logic [4:0]  addr_rf_q, addr_rf_d;
  logic [31:0] data_rf_q, data_rf_d;
  logic [31:0] pc_q, pc_d;
  logic        last_slot;
  logic [31:0] slot_addr;
  logic        wait_expired;

  assign last_slot = (idx_q == PC_SLOT);
  assign slot_addr = last_slot ? PC_ADDR : (BASE_ADDR + {24'd0, idx_q, 2'b00});

`ifdef FT_RESTORE_TIMEOUT_EN
  logic [3:0] wait_q, wait_d;

  // Counter is zero in every non-waiting state, so entering either wait state starts it fresh.
  always_comb begin
    wait_d = 4'd0;
    if ((state_q == S_GNT_WAIT && !gnt_i) || (state_q == S_RV_WAIT && !rvalid_i))
      wait_d = wait_q + 4'd1;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) wait_q <= 4'd0;
    else       wait_q <= wait_d;
  end

  assign wait_expired = (wait_q == 4'(TIMEOUT - 1));
`else
  assign wait_expired = 1'b0;
`endif

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    err_d     = err_q;
    addr_rf_d = addr_rf_q;
    data_rf_d = data_rf_q;
    pc_d      = pc_q;
    case (state_q)
      S_IDLE: begin
        if (start_i) begin
          idx_d   = 6'd1;
          err_d   = 1'b0;
          state_d = S_REQ;
        end
      end
      S_REQ: state_d = S_GNT_WAIT;
      S_GNT_WAIT: begin
        if (gnt_i) begin
          state_d = S_RV_WAIT;
        end else if (wait_expired) begin
          err_d   = 1'b1;
          state_d = S_IDLE;
        end
      end
      S_RV_WAIT: begin
        if (rvalid_i) begin
          if (err_i) begin
            err_d   = 1'b1;
            state_d = S_IDLE;
          end else begin
            // Load only the destination being written so the other side holds its value.
            if (last_slot) begin
              pc_d = rdata_i;
            end else begin
              data_rf_d = rdata_i;
              addr_rf_d = idx_q[4:0];
            end
            state_d = S_WRITE;
          end
        end else if (wait_expired) begin
          err_d   = 1'b1;
          state_d = S_IDLE;
        end
      end
      S_WRITE: begin
        if (last_slot) begin
          state_d = S_DONE;
        end else begin
          idx_d   = idx_q + 6'd1;
          state_d = S_REQ;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= S_IDLE;
      idx_q     <= 6'd0;
      err_q     <= 1'b0;
      addr_rf_q <= 5'd0;
      data_rf_q <= 32'd0;
      pc_q      <= 32'd0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      err_q     <= err_d;
      addr_rf_q <= addr_rf_d;
      data_rf_q <= data_rf_d;
      pc_q      <= pc_d;
    end
  end

  assign busy_o    = (state_q != S_IDLE);
  assign done_o    = (state_q == S_DONE);
  assign err_o     = err_q;
  assign req_o     = (state_q == S_REQ);
  assign addr_o    = req_o ? slot_addr : 32'd0;
  assign we_rf_o   = (state_q == S_WRITE) && !last_slot;
  assign pc_we_o   = (state_q == S_WRITE) && last_slot;
  assign addr_rf_o = addr_rf_q;
  assign data_rf_o = data_rf_q;
  assign pc_o      = pc_q;

endmodule
